// File: rtl/ecall_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ecall_pkg : ecall service codes and sequencer state / operation encodings
// Revision  : 1.0
// ----------------------------------------------------------------------------
package ecall_pkg;

  localparam int unsigned SVC_PRINT    = 1;
  localparam int unsigned SVC_READ_SW  = 5;
  localparam int unsigned SVC_EXIT     = 10;
  localparam int unsigned SVC_READ_KEY = 12;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRINT_WAIT = 3'd1,
    ST_READ_WAIT  = 3'd2,
    ST_COMMIT     = 3'd3,
    ST_HALT       = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_PRINT    = 2'd0,
    OP_READ_SW  = 2'd1,
    OP_READ_KEY = 2'd2
  } op_t;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edge_detect : rising-edge detector on a (debounced) level input
// Revision    : 1.0
// ----------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= level;
  end

  assign rise = level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/ecall_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ecall_sequencer : stalls the CPU on ecall and sequences print/read/exit I/O
// Revision        : 1.0
// ----------------------------------------------------------------------------
module ecall_sequencer
  import ecall_pkg::*;
#(
  parameter int unsigned PRINT_TIMEOUT = 0,
  parameter int unsigned CODE_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecall_valid,
  input  logic [CODE_W-1:0] ecall_code,
  input  logic [31:0]       a0_in,
  input  logic              conf_btn,
  input  logic [11:0]       switch_data,
  input  logic [31:0]       key_data,
  output logic              cpu_en,
  output logic              a0_wr_en,
  output logic [31:0]       a0_wr_data,
  output logic [31:0]       disp_data,
  output logic              disp_valid,
  output logic              halted
);

  localparam logic [31:0] TIMEOUT_LAST =
    (PRINT_TIMEOUT > 0) ? 32'(PRINT_TIMEOUT - 1) : 32'd0;

  state_t      r_state;
  state_t      w_state_next;
  op_t         r_op;
  logic [31:0] r_wait_cnt;
  logic        w_press;
  logic        w_timeout;
  logic        w_is_print, w_is_read_sw, w_is_read_key, w_is_exit, w_is_svc;

  edge_detect u_conf_edge (
    .clk   (clk),
    .rst   (rst),
    .level (conf_btn),
    .rise  (w_press)
  );

  assign w_is_print    = (ecall_code == CODE_W'(SVC_PRINT));
  assign w_is_read_sw  = (ecall_code == CODE_W'(SVC_READ_SW));
  assign w_is_read_key = (ecall_code == CODE_W'(SVC_READ_KEY));
  assign w_is_exit     = (ecall_code == CODE_W'(SVC_EXIT));
  assign w_is_svc      = w_is_print | w_is_read_sw | w_is_read_key | w_is_exit;

  assign w_timeout = (PRINT_TIMEOUT != 0) && (r_wait_cnt == TIMEOUT_LAST);

  // Presses are only consumed inside the wait states, so an edge coinciding
  // with the IDLE departure cycle is dropped without extra qualification.
  always_comb begin
    w_state_next = r_state;
    cpu_en       = 1'b1;
    a0_wr_en     = 1'b0;
    disp_valid   = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ecall_valid && w_is_svc) begin
          cpu_en = 1'b0;
          if (w_is_print)                        w_state_next = ST_PRINT_WAIT;
          else if (w_is_read_sw || w_is_read_key) w_state_next = ST_READ_WAIT;
          else                                    w_state_next = ST_HALT;
        end
      end
      ST_PRINT_WAIT: begin
        cpu_en     = 1'b0;
        disp_valid = 1'b1;
        if (w_press || w_timeout) w_state_next = ST_COMMIT;
      end
      ST_READ_WAIT: begin
        cpu_en = 1'b0;
        if (w_press) w_state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        a0_wr_en     = (r_op != OP_PRINT);
        w_state_next = ST_IDLE;
      end
      ST_HALT: begin
        cpu_en = 1'b0;
        halted = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_PRINT;
      r_wait_cnt <= 32'd0;
      disp_data  <= 32'd0;
      a0_wr_data <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE) begin
        r_wait_cnt <= 32'd0;
        if (ecall_valid) begin
          if (w_is_print) begin
            r_op      <= OP_PRINT;
            disp_data <= a0_in;
          end
          if (w_is_read_sw)  r_op <= OP_READ_SW;
          if (w_is_read_key) r_op <= OP_READ_KEY;
        end
      end else if ((r_state == ST_PRINT_WAIT) || (r_state == ST_READ_WAIT)) begin
        if (r_wait_cnt != CNT_MAX) r_wait_cnt <= r_wait_cnt + 32'd1;
      end
      if ((r_state == ST_READ_WAIT) && w_press) begin
        a0_wr_data <= (r_op == OP_READ_KEY) ? key_data : {20'b0, switch_data};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ecall_sequencer.sv
`default_nettype none
// tb_ecall_sequencer : two DUTs (print timeout 0 and 4) on shared stimulus,
// checked every cycle against a service-level model plus directed literals.
module tb_ecall_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall_valid;
  logic [31:0] ecall_code;
  logic [31:0] a0_in;
  logic        conf_btn;
  logic [11:0] switch_data;
  logic [31:0] key_data;

  logic        cpu_en0, wr_en0, dv0, halt0;
  logic [31:0] wr_data0, disp0;
  logic        cpu_en4, wr_en4, dv4, halt4;
  logic [31:0] wr_data4, disp4;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ecall_sequencer #(.PRINT_TIMEOUT(0), .CODE_W(32)) dut0 (
    .clk(clk), .rst(rst), .ecall_valid(ecall_valid), .ecall_code(ecall_code),
    .a0_in(a0_in), .conf_btn(conf_btn), .switch_data(switch_data), .key_data(key_data),
    .cpu_en(cpu_en0), .a0_wr_en(wr_en0), .a0_wr_data(wr_data0),
    .disp_data(disp0), .disp_valid(dv0), .halted(halt0)
  );

  ecall_sequencer #(.PRINT_TIMEOUT(4), .CODE_W(32)) dut4 (
    .clk(clk), .rst(rst), .ecall_valid(ecall_valid), .ecall_code(ecall_code),
    .a0_in(a0_in), .conf_btn(conf_btn), .switch_data(switch_data), .key_data(key_data),
    .cpu_en(cpu_en4), .a0_wr_en(wr_en4), .a0_wr_data(wr_data4),
    .disp_data(disp4), .disp_valid(dv4), .halted(halt4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- service-level model ----------------
  // busy: 0 none, otherwise the service code being waited on
  int          m_busy    [2];
  int          m_waited  [2];
  bit          m_commit  [2];
  bit          m_comm_rd [2];
  bit          m_halt    [2];
  logic [31:0] m_disp    [2];
  logic [31:0] m_wr      [2];
  bit          m_prev;

  function automatic int timeout_of(input int k);
    return (k == 0) ? 0 : 4;
  endfunction

  function automatic bit supported(input logic [31:0] c);
    return (c == 1) || (c == 5) || (c == 10) || (c == 12);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_waited[k] = 0; m_commit[k] = 0; m_comm_rd[k] = 0;
      m_halt[k] = 0; m_disp[k] = '0; m_wr[k] = '0;
    end
    m_prev = 0;
  end

  always @(posedge clk) begin
    bit press;
    press = conf_btn && !m_prev;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_waited[k] = 0; m_commit[k] = 0; m_comm_rd[k] = 0;
        m_halt[k] = 0; m_disp[k] = '0; m_wr[k] = '0;
      end else if (m_halt[k]) begin
        m_halt[k] = 1;
      end else if (m_commit[k]) begin
        m_commit[k] = 0;
      end else if (m_busy[k] == 1) begin
        if (press || (timeout_of(k) > 0 && m_waited[k] + 1 >= timeout_of(k))) begin
          m_busy[k] = 0; m_commit[k] = 1; m_comm_rd[k] = 0;
        end else begin
          m_waited[k]++;
        end
      end else if (m_busy[k] != 0) begin
        if (press) begin
          m_wr[k] = (m_busy[k] == 5) ? {20'b0, switch_data} : key_data;
          m_busy[k] = 0; m_commit[k] = 1; m_comm_rd[k] = 1;
        end
      end else if (ecall_valid) begin
        if (ecall_code == 1) begin
          m_busy[k] = 1; m_waited[k] = 0; m_disp[k] = a0_in;
        end else if (ecall_code == 5 || ecall_code == 12) begin
          m_busy[k] = int'(ecall_code);
        end else if (ecall_code == 10) begin
          m_halt[k] = 1;
        end
      end
    end
    m_prev = rst ? 1'b0 : conf_btn;
  end

  always @(negedge clk) begin
    logic e_cpu, e_wr, e_dv, e_h;
    string tag;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        e_cpu = 1; e_wr = 0; e_dv = 0; e_h = 0;
        if (m_halt[k]) begin e_cpu = 0; e_h = 1; end
        else if (m_commit[k]) e_wr = m_comm_rd[k];
        else if (m_busy[k] == 1) begin e_cpu = 0; e_dv = 1; end
        else if (m_busy[k] != 0) e_cpu = 0;
        else if (ecall_valid && supported(ecall_code)) e_cpu = 0;
        tag = (k == 0) ? "model dut0" : "model dut4";
        chk({tag, " cpu_en"},     (k == 0) ? cpu_en0  : cpu_en4,  e_cpu);
        chk({tag, " a0_wr_en"},   (k == 0) ? wr_en0   : wr_en4,   e_wr);
        chk({tag, " disp_valid"}, (k == 0) ? dv0      : dv4,      e_dv);
        chk({tag, " halted"},     (k == 0) ? halt0    : halt4,    e_h);
        chk({tag, " disp_data"},  (k == 0) ? disp0    : disp4,    m_disp[k]);
        chk({tag, " a0_wr_data"}, (k == 0) ? wr_data0 : wr_data4, m_wr[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  low, bad, cnt;
    bit  seen;
    rst = 1; ecall_valid = 0; ecall_code = 0; a0_in = 0; conf_btn = 0;
    switch_data = 0; key_data = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("reset cpu_en", cpu_en0, 1'b1);
    chk("reset halted", halt0, 1'b0);
    chk("reset disp_data", disp0, 32'h0);
    chk("reset a0_wr_data", wr_data4, 32'h0);

    // read switch with press in the 10th wait cycle
    tick();
    ecall_valid = 1; ecall_code = 5; switch_data = 12'hA5F;
    low = 0; seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) ecall_valid = 0;
      if (c == 10) conf_btn = 1;
      @(negedge clk);
      if (!cpu_en0) low++;
      if (wr_en0) begin
        seen = 1;
        chk("read_sw a0_wr_data", wr_data0, 32'h00000A5F);
        chk("read_sw commit cpu_en", cpu_en0, 1'b1);
        break;
      end
      tick();
    end
    chk("read_sw commit seen", seen, 1'b1);
    chk("read_sw stall cycles", low, 11);

    // print with no timeout: held until press
    tick(); conf_btn = 0;
    tick(); tick();
    ecall_valid = 1; ecall_code = 1; a0_in = 32'hDEADBEEF;
    @(negedge clk);
    chk("print same-cycle stall", cpu_en0, 1'b0);
    tick();
    ecall_valid = 0; a0_in = 32'h11111111;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (dv0 !== 1'b1 || disp0 !== 32'hDEADBEEF || wr_en0 !== 1'b0) bad++;
      tick();
    end
    chk("print wait hold", bad, 0);
    conf_btn = 1;
    @(negedge clk);
    chk("print press cycle stall", cpu_en0, 1'b0);
    tick();
    @(negedge clk);
    chk("print commit cpu_en", cpu_en0, 1'b1);
    chk("print commit no write", wr_en0, 1'b0);
    tick();
    conf_btn = 0; a0_in = 32'h22222222;
    @(negedge clk);
    chk("print disp_valid drop", dv0, 1'b0);
    chk("print disp_data held", disp0, 32'hDEADBEEF);

    // timeout of 4 on dut4
    tick();
    ecall_valid = 1; ecall_code = 1; a0_in = 32'hCAFEF00D;
    tick();
    ecall_valid = 0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dv4) cnt++;
      else break;
      tick();
    end
    chk("timeout wait cycles", cnt, 4);
    chk("timeout commit cpu_en", cpu_en4, 1'b1);
    chk("timeout disp_data", disp4, 32'hCAFEF00D);
    tick(); conf_btn = 1;
    tick(); tick(); conf_btn = 0;
    tick();

    // exit then reset
    ecall_valid = 1; ecall_code = 10;
    tick();
    ecall_code = 5;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!(halt0 && halt4 && !cpu_en0 && !cpu_en4 && !wr_en0 && !wr_en4)) bad++;
      tick();
      if (c % 3 == 0) conf_btn = ~conf_btn;
    end
    chk("halt absorbing", bad, 0);
    rst = 1; ecall_valid = 0;
    tick();
    rst = 0;
    @(negedge clk);
    chk("post-halt reset halted", halt0, 1'b0);
    chk("post-halt reset cpu_en", cpu_en4, 1'b1);
    chk("post-halt reset disp_data", disp0, 32'h0);

    // button already high at entry
    tick(); conf_btn = 1;
    tick(); tick();
    ecall_valid = 1; ecall_code = 12; key_data = 32'h12345678;
    tick();
    ecall_valid = 0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_en0 || cpu_en4) bad++;
      tick();
    end
    chk("held button no completion", bad, 0);
    conf_btn = 0;
    tick(); tick();
    conf_btn = 1;
    @(negedge clk);
    chk("key press cycle stall", cpu_en0, 1'b0);
    tick();
    @(negedge clk);
    chk("key commit a0_wr_en", wr_en0, 1'b1);
    chk("key commit a0_wr_data", wr_data0, 32'h12345678);
    chk("key commit dut4 a0_wr_en", wr_en4, 1'b1);
    tick(); conf_btn = 0;

    // unknown code never stalls
    ecall_valid = 1; ecall_code = 7;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!cpu_en0 || !cpu_en4) bad++;
      tick();
    end
    chk("unknown code no stall", bad, 0);
    ecall_valid = 0;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      ecall_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: ecall_code = 1;
        3, 4:    ecall_code = 5;
        5, 6:    ecall_code = 12;
        7:       ecall_code = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'd7;
        default: ecall_code = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) conf_btn = ~conf_btn;
      a0_in       = $urandom;
      switch_data = 12'($urandom);
      key_data    = $urandom;
    end
    tick();
    rst = 0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecall_sequencer.md
ECALL_SEQUENCER -- requirements
Module: ecall_sequencer

Interface
REQ-001 SHALL have parameter PRINT_TIMEOUT, default 0, print-wait cycle limit (0 = wait for confirm forever).
REQ-002 SHALL have parameter CODE_W, default 32, width of ecall service code.
REQ-003 clk  in  1  single CPU clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ecall_valid  in  1  level; ecall instruction present in decode this cycle.
REQ-006 ecall_code  in  CODE_W  service number (a7 value).
REQ-007 a0_in  in  32  current a0 register value.
REQ-008 conf_btn  in  1  debounced confirm button level.
REQ-009 switch_data  in  12  board switch value.
REQ-010 key_data  in  32  cached keyboard value.
REQ-011 cpu_en  out  1  CPU clock-enable / advance permission.
REQ-012 a0_wr_en  out  1  one-cycle write strobe for a0.
REQ-013 a0_wr_data  out  32  value to write into a0.
REQ-014 disp_data  out  32  value for LED/segment display.
REQ-015 disp_valid  out  1  print request active.
REQ-016 halted  out  1  program exited.

Function
REQ-017 Service codes SHALL be: 1 PRINT, 5 READ_SW, 12 READ_KEY, 10 EXIT; any other code SHALL be a no-op (no stall, cpu_en stays 1).
REQ-018 FSM states SHALL be IDLE, PRINT_WAIT, READ_WAIT, COMMIT, HALT.
REQ-019 cpu_en SHALL be 1 in IDLE when ecall_valid=0 or code is no-op; 0 in IDLE when ecall_valid=1 with a supported code (combinational stall, same cycle); 0 in PRINT_WAIT, READ_WAIT, HALT; 1 in COMMIT.
REQ-020 IDLE + valid PRINT: latch a0_in into disp_data, go PRINT_WAIT next cycle.
REQ-021 IDLE + valid READ_SW/READ_KEY: latch code, go READ_WAIT; IDLE + valid EXIT: go HALT.
REQ-022 conf press SHALL be the rising edge of conf_btn (registered previous level); an edge in the same cycle the FSM leaves IDLE SHALL be ignored.
REQ-023 PRINT_WAIT: disp_valid=1; on press, or when wait counter reaches PRINT_TIMEOUT-1 with PRINT_TIMEOUT>0, go COMMIT.
REQ-024 READ_WAIT: on press, a0_wr_data <= {20'b0, switch_data} (READ_SW) or key_data (READ_KEY) sampled in the press cycle; go COMMIT.
REQ-025 COMMIT SHALL last exactly one cycle; a0_wr_en=1 there only for reads; then IDLE.
REQ-026 Wait counter SHALL be 32-bit, cleared on entering each wait state, incremented per wait cycle, saturating at all-ones.
REQ-027 disp_data SHALL remain held after PRINT completes until the next PRINT latch.
REQ-028 HALT SHALL be absorbing: halted=1, cpu_en=0 until rst; presses ignored.
REQ-029 Back-to-back ecalls: ecall_valid in the cycle after COMMIT SHALL start a new sequence normally.

Reset
REQ-030 rst SHALL override all inputs in the same edge: state IDLE, cpu_en per IDLE rule, a0_wr_en 0, a0_wr_data 0, disp_data 0, disp_valid 0, halted 0, counter 0, edge register 0.
REQ-031 rst during any wait or HALT SHALL abort without issuing a0_wr_en.

Structure
REQ-032 Service-code constants and state encoding SHALL live in shared package ecall_pkg.
REQ-033 Rising-edge detector SHALL be one sub-module, edge_detect; rest is flat.

Verification
REQ-034 Read switch: code 5, switch_data=12'hA5F, conf edge after 10 cycles -> cpu_en 0 for 11 cycles, COMMIT with a0_wr_en=1, a0_wr_data=32'h00000A5F.
REQ-035 Print: code 1, a0_in=32'hDEADBEEF, PRINT_TIMEOUT=0 -> disp_valid=1, disp_data=DEADBEEF until press; no a0_wr_en; disp_data held afterward.
REQ-036 Timeout: PRINT_TIMEOUT=4, code 1, no press -> COMMIT after exactly 4 PRINT_WAIT cycles.
REQ-037 Exit + reset: code 10 -> halted=1, cpu_en=0 for 100 cycles despite presses; rst -> halted=0, IDLE.
REQ-038 Corner: conf_btn already high at ecall entry -> no completion until release and new rising edge; unknown code 7 -> cpu_en never drops.
